btn_reset_conditioner: RTL

// - Upstream of the LED counter: conditions a raw push-button into the clean synchronous

---
 rtl/btn_reset_conditioner.sv | 110 +++++++++++
 1 files changed

// File: rtl/btn_reset_conditioner.sv
// Push-button reset conditioner: polarity normalise, N-flop synchronizer, debouncer,
// power-on reset stretch. Optional edge pulses when BTN_EDGE_PULSE_EN is defined.
module btn_reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int POR_CYCLES      = 16,
  parameter int BTN_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic rst_out,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int POR_W = $clog2(POR_CYCLES + 1);

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_deb_cnt;
  logic [CNT_W-1:0]       w_deb_cnt_next;
  logic [POR_W-1:0]       r_por_cnt;
  logic                   r_rst_out;
  logic                   w_btn_norm;
  logic                   w_btn_sync;
  state_t                 r_state;
  state_t                 w_state_next;

  assign w_btn_norm = (BTN_ACTIVE_HIGH != 0) ? btn_in : ~btn_in;
  assign w_btn_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_norm};
    end
  end

  // The debounce state is the accepted level itself; the counter measures the
  // current run of samples that disagree with it.
  always_comb begin
    w_state_next   = r_state;
    w_deb_cnt_next = '0;
    if (w_btn_sync != r_state) begin
      if (r_deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        w_state_next   = (r_state == ST_PRESSED) ? ST_RELEASED : ST_PRESSED;
        w_deb_cnt_next = '0;
      end else begin
        w_deb_cnt_next = r_deb_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RELEASED;
      r_deb_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_deb_cnt <= w_deb_cnt_next;
    end
  end

  // Comparing the pre-increment count against POR_CYCLES-1 makes rst_out drop on
  // exactly the POR_CYCLES-th edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_por_cnt <= '0;
      r_rst_out <= 1'b1;
    end else begin
      if (r_por_cnt != POR_W'(POR_CYCLES)) begin
        r_por_cnt <= r_por_cnt + POR_W'(1);
      end
      r_rst_out <= (r_por_cnt < POR_W'(POR_CYCLES - 1)) | (r_state == ST_PRESSED);
    end
  end

  assign rst_out   = r_rst_out;
  assign btn_level = (r_state == ST_PRESSED);

`ifdef BTN_EDGE_PULSE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= (r_state == ST_RELEASED) && (w_state_next == ST_PRESSED);
      r_fall <= (r_state == ST_PRESSED)  && (w_state_next == ST_RELEASED);
    end
  end

  assign btn_rise = r_rise;
  assign btn_fall = r_fall;
`else
  assign btn_rise = 1'b0;
  assign btn_fall = 1'b0;
`endif

endmodule
